// File: rtl/ooocpu_spm_pkg.sv
// Shared constants and helpers for the ooocpu scratchpad data memory.
package ooocpu_spm_pkg;
  localparam int WORD_WIDTH     = 32;
  localparam int SPM_ADDR_WIDTH = 10;
  localparam int SPM_LANES      = 4;
  localparam int BYTE_WIDTH     = 8;

  // Per-lane write strobes: a lane is written only when the port is enabled.
  function automatic logic [SPM_LANES-1:0] lane_we(input logic wren,
                                                    input logic [SPM_LANES-1:0] byteena);
    return byteena & {SPM_LANES{wren}};
  endfunction
endpackage

// File: rtl/ooocpu_spm_if.sv
// Load/store-unit to scratchpad connection: one read port, one write port.
interface ooocpu_spm_if
  import ooocpu_spm_pkg::*;
#(
  parameter int ADDR_WIDTH = SPM_ADDR_WIDTH,
  parameter int DATA_WIDTH = WORD_WIDTH
);
  logic [ADDR_WIDTH-1:0] spm_rdaddress;
  logic                  spm_rden;
  logic [DATA_WIDTH-1:0] spm_rd_data;
  logic [ADDR_WIDTH-1:0] spm_wraddress;
  logic                  spm_wren;
  logic [DATA_WIDTH-1:0] spm_write_data;
  logic [SPM_LANES-1:0]  spm_store_byteena;

  modport master (
    output spm_rdaddress, spm_rden, spm_wraddress, spm_wren,
           spm_write_data, spm_store_byteena,
    input  spm_rd_data
  );

  modport slave (
    input  spm_rdaddress, spm_rden, spm_wraddress, spm_wren,
           spm_write_data, spm_store_byteena,
    output spm_rd_data
  );
endinterface

// File: rtl/ooocpu_spm_bank.sv
// One byte lane of the scratchpad: DEPTH x 8-bit RAM with a synchronous,
// read-first read port and an independent synchronous write port.
module ooocpu_spm_bank #(
  parameter int DEPTH     = 256,
  parameter int IDX_WIDTH = 8,
  parameter int WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IDX_WIDTH-1:0] rd_idx,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     rd_data,
  input  logic [IDX_WIDTH-1:0] wr_idx,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wr_data
);
  // Storage is deliberately not reset so it maps onto block RAM.
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rd_data_r;

  // Store the lane byte on an enabled write edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_idx] <= wr_data;
    end
  end

  // Capture the word as it was before this edge's write (read-first);
  // hold when not reading, clear asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= {WIDTH{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_idx];
    end
  end

  assign rd_data = rd_data_r;
endmodule

// File: rtl/ooocpu_spm.sv
// 1 KiB byte-writable scratchpad data memory for the ooocpu load/store unit.
// Built from four byte-lane banks; address bits [1:0] are ignored because
// the CPU already aligns data and generates byte enables.
module ooocpu_spm
  import ooocpu_spm_pkg::*;
#(
  parameter int ADDR_WIDTH = SPM_ADDR_WIDTH,
  parameter int DATA_WIDTH = WORD_WIDTH,
  parameter int DEPTH      = 2 ** (ADDR_WIDTH - 2)
) (
  input logic           clk,
  input logic           rst_n,
  ooocpu_spm_if.slave   spm
);
  localparam int IDX_WIDTH = ADDR_WIDTH - 2;
  localparam int LANES     = DATA_WIDTH / BYTE_WIDTH;

  logic [IDX_WIDTH-1:0]              rd_idx_s;
  logic [IDX_WIDTH-1:0]              wr_idx_s;
  logic [SPM_LANES-1:0]              lane_we_s;
  logic [LANES-1:0][BYTE_WIDTH-1:0]  rd_lane_s;
  logic                              unused_addr_bits_s;

  assign rd_idx_s  = spm.spm_rdaddress[ADDR_WIDTH-1:2];
  assign wr_idx_s  = spm.spm_wraddress[ADDR_WIDTH-1:2];
  assign lane_we_s = lane_we(spm.spm_wren, spm.spm_store_byteena);
  assign unused_addr_bits_s = ^{spm.spm_rdaddress[1:0], spm.spm_wraddress[1:0]};

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    ooocpu_spm_bank #(
      .DEPTH     (DEPTH),
      .IDX_WIDTH (IDX_WIDTH),
      .WIDTH     (BYTE_WIDTH)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_idx  (rd_idx_s),
      .rd_en   (spm.spm_rden),
      .rd_data (rd_lane_s[i]),
      .wr_idx  (wr_idx_s),
      .wr_en   (lane_we_s[i]),
      .wr_data (spm.spm_write_data[i*BYTE_WIDTH +: BYTE_WIDTH])
    );
  end

  assign spm.spm_rd_data = rd_lane_s;
endmodule

// File: tb/tb_ooocpu_spm.sv
// Directed scoreboard bench for the ooocpu scratchpad memory.
module tb_ooocpu_spm;
  logic clk;
  logic rst_n;

  ooocpu_spm_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

  ooocpu_spm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .spm   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: optional read (with expected data) and optional write.
  task automatic cycle(input logic rden, input logic [9:0] raddr, input logic [31:0] rexp,
                       input string tag, input logic wren, input logic [9:0] waddr,
                       input logic [31:0] wdata, input logic [3:0] be);
    bus.spm_rden          = rden;
    bus.spm_rdaddress     = raddr;
    bus.spm_wren          = wren;
    bus.spm_wraddress     = waddr;
    bus.spm_write_data    = wdata;
    bus.spm_store_byteena = be;
    if (rden) begin
      exp_q.push_back(rexp);
      tag_q.push_back(tag);
    end
    @(posedge clk);
    #1;
    bus.spm_rden = 1'b0;
    bus.spm_wren = 1'b0;
    if (exp_q.size() > 0) begin
      check(tag_q.pop_front(), bus.spm_rd_data, exp_q.pop_front());
    end
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
    cycle(1'b0, 10'h000, 32'h0, "", 1'b1, a, d, be);
  endtask

  task automatic rd(input logic [9:0] a, input logic [31:0] e, input string tag);
    cycle(1'b1, a, e, tag, 1'b0, 10'h000, 32'h0, 4'h0);
  endtask

  task automatic idle();
    cycle(1'b0, 10'h000, 32'h0, "", 1'b0, 10'h000, 32'h0, 4'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.spm_rden = 1'b0;          bus.spm_rdaddress = 10'h000;
    bus.spm_wren = 1'b0;          bus.spm_wraddress = 10'h000;
    bus.spm_write_data = 32'h0;   bus.spm_store_byteena = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_value", bus.spm_rd_data, 32'h0000_0000);
    rst_n = 1'b1;
    idle();

    // Full word write then read
    wr(10'h010, 32'hDEAD_BEEF, 4'b1111);
    rd(10'h010, 32'hDEAD_BEEF, "full_word");

    // Byte-lane merge
    wr(10'h020, 32'h1122_3344, 4'b1111);
    wr(10'h020, 32'hAABB_CCDD, 4'b0101);
    rd(10'h020, 32'h11BB_33DD, "lane_merge");

    // Enabled write with no lanes, and lanes with write disabled, change nothing
    wr(10'h020, 32'h0000_0000, 4'b0000);
    cycle(1'b0, 10'h000, 32'h0, "", 1'b0, 10'h020, 32'hFFFF_FFFF, 4'b1111);
    rd(10'h020, 32'h11BB_33DD, "no_lane_write");

    // Low address bits ignored
    wr(10'h043, 32'h1234_5678, 4'b1111);
    rd(10'h040, 32'h1234_5678, "align_ignore");

    // Read-during-write to the same word returns old data
    wr(10'h080, 32'h0000_0005, 4'b1111);
    cycle(1'b1, 10'h080, 32'h0000_0005, "rdw_old", 1'b1, 10'h080, 32'h0000_0009, 4'b1111);
    rd(10'h080, 32'h0000_0009, "rdw_new");

    // Simultaneous read and write to different words
    cycle(1'b1, 10'h010, 32'hDEAD_BEEF, "dual_port_rd", 1'b1, 10'h200, 32'h5A5A_A5A5, 4'b1111);
    rd(10'h200, 32'h5A5A_A5A5, "dual_port_wr");

    // Hold while rden is low
    wr(10'h100, 32'hCAFE_F00D, 4'b1111);
    rd(10'h100, 32'hCAFE_F00D, "hold_setup");
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 10'h010, 32'h0, "", 1'b1, 10'h104, 32'h0000_0001 + i, 4'b1111);
      check("hold", bus.spm_rd_data, 32'hCAFE_F00D);
    end

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", bus.spm_rd_data, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("reset_held", bus.spm_rd_data, 32'h0000_0000);
    rst_n = 1'b1;
    idle();
    rd(10'h100, 32'hCAFE_F00D, "persist_after_reset");

    // Top word, word 0 untouched
    wr(10'h000, 32'h0102_0304, 4'b1111);
    wr(10'h3FC, 32'hFFFF_FFFF, 4'b1111);
    rd(10'h3FC, 32'hFFFF_FFFF, "top_word");
    rd(10'h000, 32'h0102_0304, "word0_intact");

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
